// File: rtl/gb_lcd_capture.sv
`timescale 1ns/1ps
// gb_lcd_capture
//
// Pixel sink at the end of the PPU video output. It takes 2-bit shades
// qualified by px_valid while the PPU is in DRAW mode. It follows PPU mode
// changes to find line ends (DRAW -> anything else) and frame ends
// (entry into V_BLANK). Four pixels are packed per byte, leftmost pixel in
// the MSBs. Each byte goes through a small FIFO to a WIDTH x HEIGHT
// framebuffer over a ready/valid write port.
//
// Ports
//   clk, rstN         clock, asynchronous active-low reset
//   px_in, px_valid   pixel shade and its qualifier (one pixel per cycle)
//   ppu_mode          2'd3 = DRAW, 2'd1 = V_BLANK, others = non-draw
//   fb_wr             FIFO not empty; head entry on fb_addr / fb_data
//   fb_addr, fb_data  byte address and packed byte of the FIFO head
//   fb_ready          framebuffer takes the head when fb_wr && fb_ready
//   frame_done        one-cycle pulse once a frame has ended and the FIFO drained
//   line_err          sticky: line pixel count differed from WIDTH
//   frame_err         sticky: line count at V_BLANK entry differed from HEIGHT
//   ovf_err           sticky: a byte was dropped because the FIFO was full
//   clr_err           synchronous clear of the sticky flags (a set wins)
module gb_lcd_capture #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 144,
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [1:0]        px_in,
  input  logic              px_valid,
  input  logic [1:0]        ppu_mode,
  output logic              fb_wr,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  input  logic              fb_ready,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err,
  output logic              ovf_err,
  input  logic              clr_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0]        MODE_DRAW   = 2'd3;
  localparam logic [1:0]        MODE_VBLANK = 2'd1;
  localparam logic [7:0]        X_MAX       = 8'(WIDTH);
  localparam logic [7:0]        Y_MAX       = 8'(HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_BYTES  = ADDR_W'(WIDTH / 4);
  localparam logic [CNT_W-1:0]  FIFO_FULL   = CNT_W'(FIFO_DEPTH);

  // Raster position and packing state
  logic [7:0]        x;
  logic [7:0]        y;
  logic [ADDR_W-1:0] line_base;
  logic [5:0]        pack;        // first three shades of the current byte
  logic [1:0]        prev_mode;
  logic              frame_pending;

  // Write FIFO
  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [7:0]        mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  // Decode of the current cycle
  logic              draw;
  logic              line_end;
  logic              frame_end;
  logic              accept;
  logic              push;
  logic              push_ok;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [ADDR_W-1:0] push_addr;
  logic [7:0]        push_data;
  logic [7:0]        y_after_line;
  logic              line_err_set;
  logic              frame_err_set;
  logic              ovf_set;

  always_comb begin
    draw       = (ppu_mode == MODE_DRAW);
    line_end   = (prev_mode == MODE_DRAW) && !draw;
    frame_end  = (prev_mode != MODE_VBLANK) && (ppu_mode == MODE_VBLANK);

    accept     = px_valid && draw && (x < X_MAX) && (y < Y_MAX);
    // The fourth pixel of a byte is pushed in the same cycle it arrives.
    push       = accept && (x[1:0] == 2'd3);
    push_addr  = line_base + ADDR_W'(x[7:2]);
    push_data  = {pack, px_in};

    fifo_empty = (count == '0);
    fifo_full  = (count == FIFO_FULL);
    pop        = !fifo_empty && fb_ready;
    // When full, a simultaneous pop frees the slot that the push reuses.
    push_ok    = push && (!fifo_full || pop);
    ovf_set    = push && fifo_full && !pop;

    // Line-end effects on y come before the frame-end check of the same cycle.
    y_after_line = (line_end && (y < Y_MAX)) ? (y + 8'd1) : y;

    line_err_set  = (px_valid && draw && (x == X_MAX)) ||
                    (line_end && (x != X_MAX));
    frame_err_set = (px_valid && draw && (y >= Y_MAX)) ||
                    (frame_end && (y_after_line != Y_MAX));
  end

  // Control state: raster tracking, FIFO pointers, flags
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      x             <= '0;
      y             <= '0;
      line_base     <= '0;
      pack          <= '0;
      prev_mode     <= MODE_VBLANK;
      frame_pending <= 1'b0;
      frame_done    <= 1'b0;
      line_err      <= 1'b0;
      frame_err     <= 1'b0;
      ovf_err       <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      prev_mode <= ppu_mode;

      if (accept) begin
        x <= x + 8'd1;
        case (x[1:0])
          2'd0:    pack[5:4] <= px_in;
          2'd1:    pack[3:2] <= px_in;
          2'd2:    pack[1:0] <= px_in;
          default: pack      <= '0;
        endcase
      end

      // A line end never coincides with an accept (mode is not DRAW), so
      // these overrides cannot collide with the packing above.
      if (line_end) begin
        x    <= '0;
        pack <= '0;
      end

      if (frame_end) begin
        y         <= '0;
        line_base <= '0;
      end else begin
        y <= y_after_line;
        if (line_end && (y < Y_MAX))
          line_base <= line_base + LINE_BYTES;
      end

      frame_done <= frame_pending && fifo_empty;
      if (frame_end)
        frame_pending <= 1'b1;
      else if (frame_pending && fifo_empty)
        frame_pending <= 1'b0;

      line_err  <= (line_err  && !clr_err) || line_err_set;
      frame_err <= (frame_err && !clr_err) || frame_err_set;
      ovf_err   <= (ovf_err   && !clr_err) || ovf_set;

      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage holds data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // The head is masked while empty so the port reads zero after reset.
  always_comb begin
    fb_wr   = !fifo_empty;
    fb_addr = fifo_empty ? '0 : mem_addr[rd_ptr];
    fb_data = fifo_empty ? '0 : mem_data[rd_ptr];
  end

endmodule

// File: tb/tb_gb_lcd_capture.sv
`timescale 1ns/1ps
// Directed testbench for gb_lcd_capture.
module tb_gb_lcd_capture;

  localparam int WIDTH      = 160;
  localparam int HEIGHT     = 144;
  localparam int ADDR_W     = 13;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic [1:0]        px_in = 2'd0;
  logic              px_valid = 1'b0;
  logic [1:0]        ppu_mode = 2'd1;
  logic              fb_wr;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;
  logic              fb_ready = 1'b1;
  logic              frame_done;
  logic              line_err;
  logic              frame_err;
  logic              ovf_err;
  logic              clr_err = 1'b0;

  gb_lcd_capture #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstN(rstN), .px_in(px_in), .px_valid(px_valid),
    .ppu_mode(ppu_mode), .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_ready(fb_ready), .frame_done(frame_done), .line_err(line_err),
    .frame_err(frame_err), .ovf_err(ovf_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Write log and frame_done tracking, sampled on the falling edge.
  logic [ADDR_W-1:0] wa [$];
  logic [7:0]        wd [$];
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (fb_wr && fb_ready) begin
      wa.push_back(fb_addr);
      wd.push_back(fb_data);
      last_wr_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // 0..3: constant shade; 4: 3,2,1,0 repeating (byte E4);
  // 5: shade (group+1)%4 per 4-pixel group (bytes 55,AA,FF,00,...)
  function automatic logic [1:0] shade(input int pat, input int i);
    case (pat)
      4:       return 2'(3 - (i % 4));
      5:       return 2'(((i / 4) + 1) % 4);
      default: return 2'(pat);
    endcase
  endfunction

  task automatic send_line(input int n, input int pat);
    ppu_mode = 2'd3;
    for (int i = 0; i < n; i++) begin
      px_valid = 1'b1;
      px_in    = shade(pat, i);
      tick();
    end
    px_valid = 1'b0;
    ppu_mode = 2'd0;
    tick();
  endtask

  task automatic do_reset();
    rstN     = 1'b0;
    px_valid = 1'b0;
    px_in    = 2'd0;
    ppu_mode = 2'd1;
    fb_ready = 1'b1;
    clr_err  = 1'b0;
    idle(2);
    rstN = 1'b1;
    tick();
    wa.delete();
    wd.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    idle(2);
    n_checks++; if (fb_wr !== 1'b0) begin n_fail++; $display("FAIL reset_fb_wr: got %b expected 0", fb_wr); end
    n_checks++; if (fb_addr !== '0) begin n_fail++; $display("FAIL reset_fb_addr: got %0d expected 0", fb_addr); end
    n_checks++; if (fb_data !== 8'h00) begin n_fail++; $display("FAIL reset_fb_data: got %h expected 00", fb_data); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if ({line_err, frame_err, ovf_err} !== 3'b000) begin n_fail++; $display("FAIL reset_errs: got %b expected 000", {line_err, frame_err, ovf_err}); end
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_single_line();
    int bad;
    do_reset();
    send_line(160, 4);
    idle(8);
    n_checks++; if (wa.size() != 40) begin n_fail++; $display("FAIL line_write_count: got %0d expected 40", wa.size()); end
    bad = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== ADDR_W'(i) || wd[i] !== 8'hE4) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL line_write_content: got %0d bad entries expected 0", bad); end
    n_checks++; if ({line_err, frame_err, ovf_err} !== 3'b000) begin n_fail++; $display("FAIL line_errs: got %b expected 000", {line_err, frame_err, ovf_err}); end
    n_checks++; if (dut.y !== 8'd1) begin n_fail++; $display("FAIL line_y: got %0d expected 1", dut.y); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL line_no_done: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_full_frame();
    int bad;
    do_reset();
    for (int l = 0; l < HEIGHT; l++) send_line(160, 1);
    ppu_mode = 2'd1;
    tick();
    idle(10);
    n_checks++; if (wa.size() != 5760) begin n_fail++; $display("FAIL frame_write_count: got %0d expected 5760", wa.size()); end
    bad = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== ADDR_W'(i) || wd[i] !== 8'h55) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL frame_write_content: got %0d bad entries expected 0", bad); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL frame_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (!(done_cyc > last_wr_cyc)) begin n_fail++; $display("FAIL frame_done_order: got done cycle %0d, last write cycle %0d, expected done later", done_cyc, last_wr_cyc); end
    n_checks++; if ({line_err, frame_err, ovf_err} !== 3'b000) begin n_fail++; $display("FAIL frame_errs: got %b expected 000", {line_err, frame_err, ovf_err}); end
    n_checks++; if (dut.y !== 8'd0) begin n_fail++; $display("FAIL frame_y: got %0d expected 0", dut.y); end
  endtask

  task automatic test_short_line();
    int bad;
    do_reset();
    send_line(100, 4);
    send_line(160, 4);
    idle(8);
    n_checks++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL short_line_err: got %b expected 1", line_err); end
    n_checks++; if (wa.size() != 65) begin n_fail++; $display("FAIL short_write_count: got %0d expected 65", wa.size()); end
    bad = 0;
    for (int i = 0; i < 25 && i < wa.size(); i++)
      if (wa[i] !== ADDR_W'(i)) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL short_first_addrs: got %0d bad entries expected 0", bad); end
    if (wa.size() == 65) begin
      n_checks++; if (wa[25] !== 13'd40) begin n_fail++; $display("FAIL short_second_start: got %0d expected 40", wa[25]); end
      n_checks++; if (wa[64] !== 13'd79) begin n_fail++; $display("FAIL short_second_end: got %0d expected 79", wa[64]); end
    end
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    fb_ready = 1'b0;
    ppu_mode = 2'd3;
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      if (i == 40) fb_ready = 1'b1;
      px_valid = 1'b1;
      px_in    = shade(5, i);
      tick();
      if (i >= 3 && i < 40)
        if (fb_wr !== 1'b1 || fb_addr !== 13'd0 || fb_data !== 8'h55) bad++;
    end
    px_valid = 1'b0;
    ppu_mode = 2'd0;
    tick();
    idle(8);
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ovf_stall_stable: got %0d unstable cycles expected 0", bad); end
    n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", ovf_err); end
    n_checks++; if (wa.size() != 34) begin n_fail++; $display("FAIL ovf_write_count: got %0d expected 34", wa.size()); end
    if (wa.size() == 34) begin
      n_checks++; if ({wa[0], wa[1], wa[2], wa[3]} !== {13'd0, 13'd1, 13'd2, 13'd3}) begin n_fail++; $display("FAIL ovf_head_addrs: got %0d %0d %0d %0d expected 0 1 2 3", wa[0], wa[1], wa[2], wa[3]); end
      n_checks++; if ({wd[0], wd[1], wd[2], wd[3]} !== 32'h55AAFF00) begin n_fail++; $display("FAIL ovf_head_data: got %h%h%h%h expected 55AAFF00", wd[0], wd[1], wd[2], wd[3]); end
      n_checks++; if (wa[4] !== 13'd10 || wd[4] !== 8'hFF) begin n_fail++; $display("FAIL ovf_resume: got addr %0d data %h expected addr 10 data ff", wa[4], wd[4]); end
      n_checks++; if (wa[33] !== 13'd39) begin n_fail++; $display("FAIL ovf_last: got %0d expected 39", wa[33]); end
    end
  endtask

  task automatic test_long_line_and_clear();
    do_reset();
    ppu_mode = 2'd3;
    for (int i = 0; i < 161; i++) begin
      px_valid = 1'b1;
      px_in    = shade(4, i);
      tick();
      if (i == 159) begin
        n_checks++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL long_no_early_err: got %b expected 0", line_err); end
      end
    end
    n_checks++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL long_line_err: got %b expected 1", line_err); end
    px_valid = 1'b0;
    ppu_mode = 2'd0;
    tick();
    idle(8);
    n_checks++; if (wa.size() != 40) begin n_fail++; $display("FAIL long_write_count: got %0d expected 40", wa.size()); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_checks++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL clear_line_err: got %b expected 0", line_err); end
    ppu_mode = 2'd3;
    for (int i = 0; i < 161; i++) begin
      px_valid = 1'b1;
      px_in    = shade(4, i);
      if (i == 160) clr_err = 1'b1;
      tick();
    end
    clr_err  = 1'b0;
    px_valid = 1'b0;
    n_checks++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear: got %b expected 1", line_err); end
    ppu_mode = 2'd0;
    tick();
    idle(8);
    n_checks++; if (wa.size() != 80) begin n_fail++; $display("FAIL long_second_count: got %0d expected 80", wa.size()); end
  endtask

  task automatic test_reset_midline();
    do_reset();
    fb_ready = 1'b0;
    ppu_mode = 2'd3;
    for (int i = 0; i < 8; i++) begin
      px_valid = 1'b1;
      px_in    = shade(4, i);
      tick();
    end
    n_checks++; if (fb_wr !== 1'b1) begin n_fail++; $display("FAIL midreset_queued: got %b expected 1", fb_wr); end
    #2;
    rstN = 1'b0;
    #1;
    n_checks++; if (fb_wr !== 1'b0) begin n_fail++; $display("FAIL midreset_fb_wr: got %b expected 0", fb_wr); end
    px_valid = 1'b0;
    ppu_mode = 2'd0;
    fb_ready = 1'b1;
    tick();
    tick();
    rstN = 1'b1;
    wa.delete();
    wd.delete();
    tick();
    send_line(160, 4);
    idle(8);
    n_checks++; if (wa.size() != 40) begin n_fail++; $display("FAIL midreset_count: got %0d expected 40", wa.size()); end
    if (wa.size() == 40) begin
      n_checks++; if (wa[0] !== 13'd0 || wa[39] !== 13'd39) begin n_fail++; $display("FAIL midreset_addrs: got %0d..%0d expected 0..39", wa[0], wa[39]); end
    end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d expected 0", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_full_frame();
    test_short_line();
    test_overflow();
    test_long_line_and_clear();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
